// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo_v2 FIFO and its testbench:
//   fifo_mode_e   read-mode selector (standard registered / first-word-fall-through)
//   DEF_*         default parameter values
//   ptr_width()   width of a read/write pointer for a given depth
//   cnt_width()   width of the fill-level counter for a given depth
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_MARGIN = 2;
    localparam int DEF_AE_MARGIN = 2;

    // A pointer addresses 0..depth-1; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // The counter must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// FIFO_DEPTH x DWIDTH storage array with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk     in   write clock (rising edge)
//   we      in   write enable
//   waddr   in   write address (0..FIFO_DEPTH-1)
//   wdata   in   write data
//   raddr   in   read address (0..FIFO_DEPTH-1)
//   rdata   out  read data, follows raddr combinationally
// ---------------------------------------------------------------------------
module fifo_ram #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0]    wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [DWIDTH-1:0]    rdata
);

    logic [DWIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// ---------------------------------------------------------------------------
// sync_fifo_v2
// Single-clock FIFO with arbitrary depth, almost-full/almost-empty margins,
// standard or first-word-fall-through read mode, fill level and sticky
// overflow/underflow flags, plus a synchronous flush.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   flush        in   synchronous clear (pointers, count, error flags)
//   wr_en        in   write request
//   in_data      in   write data
//   rd_en        in   read request (FWFT: pop head)
//   out_data     out  read data
//   full         out  count == FIFO_DEPTH
//   empty        out  count == 0
//   almostfull   out  count >= FIFO_DEPTH-AF_MARGIN
//   almostempty  out  count <= AE_MARGIN
//   count        out  current fill level
//   overflow     out  sticky: write dropped because FIFO was full
//   underflow    out  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH,
    parameter int AF_MARGIN  = DEF_AF_MARGIN,
    parameter int AE_MARGIN  = DEF_AE_MARGIN,
    parameter int FWFT       = 0,
    localparam int PTR_WIDTH = ptr_width(FIFO_DEPTH),
    localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [DWIDTH-1:0]    in_data,
    input  logic                 rd_en,
    output logic [DWIDTH-1:0]    out_data,
    output logic                 full,
    output logic                 empty,
    output logic                 almostfull,
    output logic                 almostempty,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_LVL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_LVL    = CNT_WIDTH'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CNT_WIDTH-1:0] AE_LVL    = CNT_WIDTH'(AE_MARGIN);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [PTR_WIDTH-1:0] wptr_next;
    logic [PTR_WIDTH-1:0] rptr_next;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 do_rd;
    logic                 do_wr;
    logic [DWIDTH-1:0]    rd_data;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // A read frees a slot in the same edge, so a full FIFO can still accept
    // a write when it is read simultaneously.
    always_comb begin
        do_rd      = rd_en & ~empty;
        do_wr      = wr_en & (~full | do_rd);
        wptr_next  = do_wr ? ptr_inc(wptr) : wptr;
        rptr_next  = do_rd ? ptr_inc(rptr) : rptr;
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CNT_ONE;
        end else if (do_rd && !do_wr) begin
            count_next = count - CNT_ONE;
        end
    end

    fifo_ram #(
        .DWIDTH     (DWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr & ~flush),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Pointers, count and all status flags; flags are registered from
    // count_next so they always agree with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            almostempty <= 1'b1;
            full        <= 1'b0;
            almostfull  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            empty       <= 1'b1;
            almostempty <= 1'b1;
            full        <= 1'b0;
            almostfull  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wptr        <= wptr_next;
            rptr        <= rptr_next;
            count       <= count_next;
            empty       <= (count_next == '0);
            almostempty <= (count_next <= AE_LVL);
            full        <= (count_next == DEPTH_LVL);
            almostfull  <= (count_next >= AF_LVL);
            if (wr_en && !do_wr) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; zero while empty keeps the
            // output quiet after reset/flush.
            assign out_data = empty ? '0 : rd_data;
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data <= '0;
                end else if (do_rd && !flush) begin
                    out_data <= rd_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
module tb_sync_fifo_v2;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AFM   = 2;
    localparam int AEM   = 2;
    localparam int CW    = cnt_width(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] in_data;

    logic [DW-1:0] s_out, f_out;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    always #5 clk = ~clk;

    sync_fifo_v2 #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .in_data(in_data), .rd_en(rd_en),
        .out_data(s_out), .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_v2 #(.DWIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .in_data(in_data), .rd_en(rd_en),
        .out_data(f_out), .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf));

    int total = 0;
    int bad   = 0;

    // Reference model: queue scoreboard plus sticky flags and the standard-mode output register.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_out;

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          fl;
        int            e_cnt;
        logic          e_empty;
        logic          e_unf;
        logic [DW-1:0] e_out;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count",        32'(s_count), 32'(sz));
        chk("empty",        32'(s_empty), 32'(sz == 0));
        chk("full",         32'(s_full),  32'(sz == DEPTH));
        chk("almostfull",   32'(s_af),    32'(sz >= DEPTH - AFM));
        chk("almostempty",  32'(s_ae),    32'(sz <= AEM));
        chk("overflow",     32'(s_ovf),   32'(m_ovf));
        chk("underflow",    32'(s_unf),   32'(m_unf));
        chk("std_out",      32'(s_out),   32'(m_out));
        chk("fwft_count",   32'(f_count), 32'(sz));
        chk("fwft_flags",   {28'd0, f_empty, f_full, f_af, f_ae},
                            {28'd0, sz == 0, sz == DEPTH, sz >= DEPTH - AFM, sz <= AEM});
        chk("fwft_err",     {30'd0, f_ovf, f_unf}, {30'd0, m_ovf, m_unf});
        if (sz > 0) chk("fwft_head", 32'(f_out), 32'(q[0]));
    endtask

    // One clock: inputs applied at the falling edge, model advanced at the
    // rising edge, outputs checked at the next falling edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        int  sz;
        bit  mrd, mwr;
        wr_en   = w;
        in_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        sz = q.size();
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            mrd = r && (sz > 0);
            mwr = w && ((sz < DEPTH) || mrd);
            if (r && sz == 0) m_unf = 1'b1;
            if (w && !mwr)    m_ovf = 1'b1;
            if (mrd) m_out = q.pop_front();
            if (mwr) q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(s_count), 32'd0);
        chk({tag, "_flags"}, {26'd0, s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, {26'd0, 6'b110000});
        chk({tag, "_out"},   32'(s_out), 32'd0);
        chk({tag, "_fwft"},  {26'd0, f_empty, f_ae, f_full, f_af, f_ovf, f_unf}, {26'd0, 6'b110000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; in_data = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_out = '0;
        vecs[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hA1};
        vecs[3] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'hA2};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'hA3};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hA3};
        vecs[6] = '{1'b1, 8'hB0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hA3};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'hA3};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Table-driven basic sequence
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_empty", i), 32'(s_empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_unf", i),   32'(s_unf),   32'(vecs[i].e_unf));
            chk($sformatf("vec%0d_out", i),   32'(s_out),   32'(vecs[i].e_out));
        end

        // Asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("pre_reset_count", 32'(s_count), 32'd5);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_out = '0;
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Fill to full, then drain three times across the pointer wrap
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 1; i <= DEPTH; i++) begin
                step(1'b1, 8'(i), 1'b0, 1'b0);
                if (i == DEPTH - 3) chk("af_before", 32'(s_af), 32'd0);
                if (i == DEPTH - 2) chk("af_at_10", {30'd0, s_af, s_full}, 32'b10);
            end
            chk("full_at_12", 32'(s_full), 32'd1);
            for (int i = 1; i <= DEPTH; i++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                chk("wrap_data", 32'(s_out), 32'(i));
            end
        end

        // Full boundary: simultaneous read/write, then dropped write
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("full_rw_count", 32'(s_count), 32'd12);
        chk("full_rw_ovf",   32'(s_ovf),   32'd0);
        step(1'b1, 8'h0D, 1'b0, 1'b0);
        chk("drop_wr_ovf",   32'(s_ovf),   32'd1);
        chk("drop_wr_count", 32'(s_count), 32'd12);
        for (int i = 2; i <= DEPTH + 1; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(s_out), (i == DEPTH + 1) ? 32'h77 : 32'(i));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_rd_unf", 32'(s_unf), 32'd1);
        chk("empty_rd_out", 32'(s_out), 32'h77);

        // Read latency in each mode
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_vis",   32'(f_out),   32'hA5);
        chk("fwft_nempt", 32'(f_empty), 32'd0);
        chk("std_hold",   32'(s_out),   32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(f_empty), 32'd1);
        chk("std_rd_data",    32'(s_out),   32'hA5);

        // Flush with both errors set and a same-cycle write
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_flush_state", {s_count, s_ovf, s_unf}, {CW'(7), 2'b11});
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_state", {s_count, s_empty, s_ovf, s_unf}, {CW'(0), 3'b100});
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_discard", 32'(s_out), 32'h33);

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
